// File: rtl/timer_capture.sv
// rtl/timer_capture.sv - capture path for one timer capture/compare channel
// Selects a source, synchronises it, qualifies edges and latches TAxR into CaptureValue.
module timer_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        TimerTick,
  input  logic [15:0] TAxRcurrent,
  input  logic        CAP,
  input  logic [1:0]  CM,
  input  logic [1:0]  CCIS,
  input  logic        SCS,
  input  logic        EQUn,
  input  logic        CCIFGcur,
  input  logic        CCInA,
  input  logic        CCInB,
  output logic [15:0] CaptureValue,
  output logic        CapValid,
  output logic        COVset,
  output logic        CCIout,
  output logic        SCCIout
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   cci_dly_q, cci_dly_d;
  logic                   event_q, event_d;
  logic                   scci_q, scci_d;
  logic [15:0]            cap_value_q, cap_value_d;
  logic                   cap_valid_q, cap_valid_d;
  logic                   cov_q, cov_d;

  logic cci_mux;
  logic cci_s;
  logic rise;
  logic fall;
  logic do_capture;

  // Muxing ahead of the synchroniser makes a CCIS switch look like an input edge.
  always_comb begin
    cci_mux = 1'b0;
    case (CCIS)
      2'b00:   cci_mux = CCInA;
      2'b01:   cci_mux = CCInB;
      2'b10:   cci_mux = 1'b0;
      default: cci_mux = 1'b1;
    endcase
  end

  assign cci_s = sync_q[SYNC_STAGES-1];
  assign rise  = cci_s & ~cci_dly_q;
  assign fall  = ~cci_s & cci_dly_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], cci_mux};
    cci_dly_d = cci_s;
    event_d   = CAP & ((CM[0] & rise) | (CM[1] & fall));
    scci_d    = EQUn ? cci_s : scci_q;
  end

  always_comb begin
    state_d     = state_q;
    cap_value_d = cap_value_q;
    cap_valid_d = 1'b0;
    cov_d       = 1'b0;
    do_capture  = 1'b0;
    if (!CAP) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (event_q) begin
            if (!SCS || TimerTick) begin
              do_capture = 1'b1;
            end else begin
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          // A further event before the tick is an overflow; still one capture.
          if (event_q) begin
            cov_d = 1'b1;
          end
          if (TimerTick) begin
            do_capture = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (do_capture) begin
      cap_value_d = TAxRcurrent;
      cap_valid_d = 1'b1;
      if (CCIFGcur) begin
        cov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      cci_dly_q   <= 1'b0;
      event_q     <= 1'b0;
      scci_q      <= 1'b0;
      cap_value_q <= 16'h0000;
      cap_valid_q <= 1'b0;
      cov_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cci_dly_q   <= cci_dly_d;
      event_q     <= event_d;
      scci_q      <= scci_d;
      cap_value_q <= cap_value_d;
      cap_valid_q <= cap_valid_d;
      cov_q       <= cov_d;
    end
  end

  assign CaptureValue = cap_value_q;
  assign CapValid     = cap_valid_q;
  assign COVset       = cov_q;
  assign CCIout       = cci_s;
  assign SCCIout      = scci_q;

endmodule

// File: tb/tb_timer_capture.sv
// tb/tb_timer_capture.sv - scoreboard bench for timer_capture
// Reference model predicts capture/overflow pulses per cycle; a monitor pops and compares.
module tb_timer_capture;
  localparam int S = 2;

  logic        MCLK = 1'b0;
  logic        reset = 1'b1;
  logic        TimerTick = 1'b0;
  logic [15:0] TAxRcurrent = 16'h0000;
  logic        CAP = 1'b0;
  logic [1:0]  CM = 2'b00;
  logic [1:0]  CCIS = 2'b00;
  logic        SCS = 1'b0;
  logic        EQUn = 1'b0;
  logic        CCIFGcur = 1'b0;
  logic        CCInA = 1'b0;
  logic        CCInB = 1'b0;
  logic [15:0] CaptureValue;
  logic        CapValid;
  logic        COVset;
  logic        CCIout;
  logic        SCCIout;

  timer_capture #(.SYNC_STAGES(S)) dut (
    .MCLK(MCLK), .reset(reset), .TimerTick(TimerTick), .TAxRcurrent(TAxRcurrent),
    .CAP(CAP), .CM(CM), .CCIS(CCIS), .SCS(SCS), .EQUn(EQUn), .CCIFGcur(CCIFGcur),
    .CCInA(CCInA), .CCInB(CCInB), .CaptureValue(CaptureValue), .CapValid(CapValid),
    .COVset(COVset), .CCIout(CCIout), .SCCIout(SCCIout)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int          cyc;
    bit          cap;
    bit          cov;
    logic [15:0] val;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model state: hist[0] is the selected level sampled at the latest edge.
  logic [S+2:0] hist = '0;
  bit           pend = 1'b0;
  logic         scci_m = 1'b0;
  logic [15:0]  capv_m = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic sel_level();
    case (CCIS)
      2'b00:   return CCInA;
      2'b01:   return CCInB;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // A level change sampled at edge n becomes a qualified event handled at edge n+S+1.
  always @(posedge MCLK or posedge reset) begin
    exp_t e;
    bit   ev, cap_now, cov_now;
    cyc++;
    if (reset) begin
      hist   = '0;
      pend   = 1'b0;
      scci_m = 1'b0;
      capv_m = 16'h0000;
      expq.delete();
    end else begin
      if (EQUn) scci_m = hist[S-1];
      hist    = {hist[S+1:0], sel_level()};
      ev      = CAP && ((CM[0] && hist[S+1] && !hist[S+2]) || (CM[1] && !hist[S+1] && hist[S+2]));
      cap_now = 1'b0;
      cov_now = 1'b0;
      if (!CAP) begin
        pend = 1'b0;
      end else if (pend) begin
        cov_now = ev;
        if (TimerTick) begin
          cap_now = 1'b1;
          pend    = 1'b0;
        end
      end else if (ev) begin
        if (!SCS || TimerTick) cap_now = 1'b1;
        else pend = 1'b1;
      end
      if (cap_now) begin
        capv_m  = TAxRcurrent;
        cov_now = cov_now || CCIFGcur;
      end
      if (cap_now || cov_now) begin
        e.cyc = cyc;
        e.cap = cap_now;
        e.cov = cov_now;
        e.val = TAxRcurrent;
        expq.push_back(e);
      end
    end
  end

  always @(negedge MCLK) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      chk("missing_pulse", 32'd0, 32'd1);
    end
    chk("CCIout", {31'd0, CCIout}, {31'd0, hist[S-1]});
    chk("SCCIout", {31'd0, SCCIout}, {31'd0, scci_m});
    chk("CaptureValue", {16'd0, CaptureValue}, {16'd0, capv_m});
    if (CapValid || COVset) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("CapValid", {31'd0, CapValid}, {31'd0, e.cap});
        chk("COVset", {31'd0, COVset}, {31'd0, e.cov});
      end else begin
        chk("unexpected_pulse", {30'd0, CapValid, COVset}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic tick();
    TimerTick = 1'b1;
    step(1);
    TimerTick = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      TAxRcurrent = 16'($urandom);
      TimerTick   = ($urandom_range(0, 3) == 0);
      CCIFGcur    = 1'($urandom);
      EQUn        = 1'($urandom);
      step(1);
    end
  endtask

  initial begin
    step(3);
    reset = 1'b0;

    // Immediate capture, rising edge on CCInA.
    CAP = 1'b1; CM = 2'b01; CCIS = 2'b00; SCS = 1'b0; TAxRcurrent = 16'h1234;
    step(2);
    CCInA = 1'b1;
    step(8);

    // Tick-aligned capture takes the value present on the tick cycle.
    SCS = 1'b1; CCInA = 1'b0;
    step(6);
    TAxRcurrent = 16'h0010; CCInA = 1'b1;
    step(5);
    TAxRcurrent = 16'h0011;
    tick();
    step(4);

    // Both edges on CCInB with CCIFG already set.
    SCS = 1'b0; CM = 2'b11; CCIS = 2'b01; CCInB = 1'b1; TAxRcurrent = 16'h0abc;
    step(6);
    CCIFGcur = 1'b1; CCInB = 1'b0; TAxRcurrent = 16'h0abd;
    step(6);
    CCIFGcur = 1'b0;

    // Two rising edges before the tick.
    SCS = 1'b1; CM = 2'b01; CCIS = 2'b00; CCInA = 1'b0;
    step(6);
    CCInA = 1'b1; step(3);
    CCInA = 1'b0; step(3);
    CCInA = 1'b1; step(4);
    TAxRcurrent = 16'h0777;
    tick();
    step(4);

    // Software capture via CCIS, then CAP drop while pending, then SCCI latch.
    SCS = 1'b0; CCIS = 2'b10; step(6);
    CCIS = 2'b11; TAxRcurrent = 16'h5a5a; step(6);
    SCS = 1'b1; CCIS = 2'b10; step(6);
    CCIS = 2'b11; step(5);
    CAP = 1'b0; step(1);
    tick();
    step(3);
    EQUn = 1'b1; step(2);
    EQUn = 1'b0; step(2);

    // Reset while pending drops the capture.
    CAP = 1'b1; CCIS = 2'b10; step(6);
    CCIS = 2'b11; step(5);
    reset = 1'b1; step(3);
    reset = 1'b0;
    tick();
    step(6);
    CAP = 1'b0; step(3);

    for (int it = 0; it < 40; it++) begin
      CAP = ($urandom_range(0, 3) != 0);
      CM  = 2'($urandom);
      SCS = 1'($urandom);
      rand_cycles(S + 3);
      repeat ($urandom_range(1, 5)) begin
        CCInA = 1'($urandom);
        CCInB = 1'($urandom);
        CCIS  = 2'($urandom);
        rand_cycles($urandom_range(2, 5));
      end
      rand_cycles(S + 3);
    end

    TimerTick = 1'b0; CAP = 1'b0;
    step(4);
    chk("queue_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
